// File: rtl/stall_ctrl_pkg.sv
// stall_ctrl_pkg: shared definitions for the pipeline stall/flush sequencer.
//   md_state_e      - sequencer FSM state encoding (RUN / MD_WAIT / MD_DONE)
//   MUL_CYCLES_DEF  - default EX-stall length of a multiply
//   DIV_CYCLES_DEF  - default EX-stall length of a divide
//   REG_ZERO        - architectural zero register, used as the "no destination" tag
package stall_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_WAIT = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  localparam int MUL_CYCLES_DEF = 4;
  localparam int DIV_CYCLES_DEF = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/stall_ctrl_if.sv
// stall_ctrl_if: hazard-request / pipeline-control bundle of the stall sequencer.
//   i_*  hazard requests and ID-stage instruction info (driven by the hazard side)
//   o_*  PC / IF-ID / ID-EX controls, mult/div status, EX destination, perf counters
// Modports:
//   master - hazard/pipeline side: drives i_*, observes o_*
//   slave  - stall_ctrl: consumes i_*, drives o_*
interface stall_ctrl_if;

  logic [4:0]  i_wra;
  logic        i_wen;
  logic        i_pause;
  logic        i_loadUse;
  logic        i_branchTaken;
  logic        i_mdStart;
  logic        i_mdIsDiv;

  logic        o_pcEn;
  logic        o_ifidEn;
  logic        o_ifidFlush;
  logic        o_idexFlush;
  logic        o_mdBusy;
  logic        o_mdDone;
  logic [4:0]  o_wra;
  logic [31:0] o_perfStall;
  logic [31:0] o_perfFlush;

  modport master (
    output i_wra, i_wen, i_pause, i_loadUse, i_branchTaken, i_mdStart, i_mdIsDiv,
    input  o_pcEn, o_ifidEn, o_ifidFlush, o_idexFlush, o_mdBusy, o_mdDone,
           o_wra, o_perfStall, o_perfFlush
  );

  modport slave (
    input  i_wra, i_wen, i_pause, i_loadUse, i_branchTaken, i_mdStart, i_mdIsDiv,
    output o_pcEn, o_ifidEn, o_ifidFlush, o_idexFlush, o_mdBusy, o_mdDone,
           o_wra, o_perfStall, o_perfFlush
  );

endinterface

// File: rtl/stall_perf_cnt.sv
// stall_perf_cnt: 32-bit saturating event counter.
// Ports:
//   clk    core clock, rising edge
//   rstn   asynchronous active-low reset, loads INIT_VAL
//   i_inc  count one event this cycle
//   o_cnt  current count; sticks at 32'hFFFFFFFF once reached
// Parameter INIT_VAL is the value loaded by reset (0 in the core).
module stall_perf_cnt #(
  parameter logic [31:0] INIT_VAL = 32'd0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_inc,
  output logic [31:0] o_cnt
);

  logic [31:0] cnt_q;

  // NOTE: sequential state is written with non-blocking (<=) so every flop
  // samples values from before the edge, independent of block ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= INIT_VAL;
    end else if (i_inc && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/stall_ctrl.sv
// stall_ctrl: pipeline stall/flush sequencer for the five-stage core.
// Turns hazard requests (pause, load-use, taken branch, mult/div start) into
// PC / IF-ID / ID-EX enables and flushes, sequences multi-cycle mult/div EX
// stalls, and emits the bubble-aware EX destination register for forwarding.
// Ports:
//   clk   core clock, rising edge
//   rstn  asynchronous active-low reset
//   bus   stall_ctrl_if.slave (hazard inputs i_*, pipeline controls o_*)
// Parameters: MUL_CYCLES (>=1), DIV_CYCLES (>=MUL_CYCLES) EX-stall lengths.
// Build option: define STALL_CTRL_PERF_EN to build the saturating stall/flush
// cycle counters; otherwise o_perfStall/o_perfFlush are constant 0.
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic         clk,
  input  logic         rstn,
  stall_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;

  logic stall_req;
  logic in_wait;
  logic issue;
  logic md_issue;
  logic pc_en;
  logic ifid_flush;

  assign stall_req = bus.i_pause | bus.i_loadUse;
  assign in_wait   = (state_q == MD_WAIT);
  // An ID instruction advances into EX only when neither a mult/div is
  // occupying EX nor a hazard holds it in ID.
  assign issue     = ~in_wait & ~stall_req;
  assign md_issue  = issue & bus.i_mdStart;

  // NOTE: combinational outputs are continuous assigns of full expressions,
  // so every output has a value on every path and no latch can be inferred.
  assign pc_en           = issue;
  assign ifid_flush      = issue & bus.i_branchTaken;
  assign bus.o_pcEn      = pc_en;
  assign bus.o_ifidEn    = issue;
  assign bus.o_idexFlush = ~issue;
  assign bus.o_ifidFlush = ifid_flush;
  assign bus.o_mdBusy    = in_wait;
  assign bus.o_mdDone    = (state_q == MD_DONE);

  // NOTE: only the control state is reset; an async reset mid-MD_WAIT drops
  // straight back to RUN, so no o_mdDone is ever produced for that op.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        RUN, MD_DONE: begin
          // MD_DONE behaves like RUN, so a back-to-back mult/div re-enters
          // MD_WAIT without an intervening RUN cycle.
          if (md_issue) begin
            state_q <= MD_WAIT;
            cnt_q   <= bus.i_mdIsDiv ? DIV_LOAD : MUL_LOAD;
          end else begin
            state_q <= RUN;
          end
        end
        MD_WAIT: begin
          if (cnt_q == '0) begin
            state_q <= MD_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  // EX destination as seen by forwarding: bubbles carry the zero register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.o_wra <= REG_ZERO;
    end else begin
      bus.o_wra <= (issue && bus.i_wen) ? bus.i_wra : REG_ZERO;
    end
  end

`ifdef STALL_CTRL_PERF_EN
  stall_perf_cnt #(.INIT_VAL(32'd0)) u_perf_stall (
    .clk   (clk),
    .rstn  (rstn),
    .i_inc (~pc_en),
    .o_cnt (bus.o_perfStall)
  );

  stall_perf_cnt #(.INIT_VAL(32'd0)) u_perf_flush (
    .clk   (clk),
    .rstn  (rstn),
    .i_inc (ifid_flush),
    .o_cnt (bus.o_perfFlush)
  );
`else
  assign bus.o_perfStall = 32'd0;
  assign bus.o_perfFlush = 32'd0;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// tb_stall_ctrl: directed self-checking bench for stall_ctrl.
// A reference model tracks the sequencer state from the specified behaviour;
// the expected EX destination is pushed to a scoreboard queue when each cycle's
// stimulus is applied and popped when the DUT registers it on the next edge.
module tb_stall_ctrl;
  import stall_ctrl_pkg::*;

  localparam int MUL_C = 4;
  localparam int DIV_C = 32;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  stall_ctrl_if bus ();

  stall_ctrl #(.MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Standalone counter preloaded near the top to exercise saturation.
  logic        sat_rstn;
  logic        sat_inc;
  logic [31:0] sat_cnt;
  stall_perf_cnt #(.INIT_VAL(32'hFFFF_FFFE)) u_sat (
    .clk   (clk),
    .rstn  (sat_rstn),
    .i_inc (sat_inc),
    .o_cnt (sat_cnt)
  );

  int errors = 0;
  int checks = 0;

  logic [4:0] wra_sb[$];
  md_state_e  m_state;
  int         m_cnt;
  int         m_stall;
  int         m_flush;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic quiet();
    bus.i_wra         = 5'd0;
    bus.i_wen         = 1'b0;
    bus.i_pause       = 1'b0;
    bus.i_loadUse     = 1'b0;
    bus.i_branchTaken = 1'b0;
    bus.i_mdStart     = 1'b0;
    bus.i_mdIsDiv     = 1'b0;
  endtask

  task automatic model_reset();
    m_state = RUN;
    m_cnt   = 0;
    m_stall = 0;
    m_flush = 0;
    wra_sb.delete();
  endtask

  // One clock cycle with the inputs currently applied: check the combinational
  // controls, push the expected EX destination, advance the model, then pop and
  // compare after the edge.
  task automatic cycle(input string tag);
    logic stall, iss;
    logic [4:0] exp_wra;
    #1;
    stall = bus.i_pause | bus.i_loadUse;
    iss   = (m_state != MD_WAIT) && !stall;
    check({tag, ".pcEn"},      {31'd0, bus.o_pcEn},      {31'd0, iss});
    check({tag, ".ifidEn"},    {31'd0, bus.o_ifidEn},    {31'd0, iss});
    check({tag, ".idexFlush"}, {31'd0, bus.o_idexFlush}, {31'd0, !iss});
    check({tag, ".ifidFlush"}, {31'd0, bus.o_ifidFlush}, {31'd0, iss && bus.i_branchTaken});
    check({tag, ".mdBusy"},    {31'd0, bus.o_mdBusy},    {31'd0, m_state == MD_WAIT});
    check({tag, ".mdDone"},    {31'd0, bus.o_mdDone},    {31'd0, m_state == MD_DONE});
    wra_sb.push_back((iss && bus.i_wen) ? bus.i_wra : 5'd0);
    if (!iss) m_stall++;
    if (iss && bus.i_branchTaken) m_flush++;
    case (m_state)
      MD_WAIT: begin
        if (m_cnt == 0) m_state = MD_DONE;
        else m_cnt--;
      end
      default: begin
        if (iss && bus.i_mdStart) begin
          m_state = MD_WAIT;
          m_cnt   = bus.i_mdIsDiv ? DIV_C - 1 : MUL_C - 1;
        end else begin
          m_state = RUN;
        end
      end
    endcase
    @(posedge clk);
    #1;
    exp_wra = wra_sb.pop_front();
    check({tag, ".wra"}, {27'd0, bus.o_wra}, {27'd0, exp_wra});
`ifdef STALL_CTRL_PERF_EN
    check({tag, ".perfStall"}, bus.o_perfStall, m_stall);
    check({tag, ".perfFlush"}, bus.o_perfFlush, m_flush);
`else
    check({tag, ".perfStall"}, bus.o_perfStall, 32'd0);
    check({tag, ".perfFlush"}, bus.o_perfFlush, 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    quiet();
    sat_inc  = 1'b0;
    sat_rstn = 1'b0;
    rstn     = 1'b0;
    model_reset();

    // Reset with a pause held: RUN controls stalled, EX destination zero.
    bus.i_pause = 1'b1;
    #1;
    check("rst.wra",       {27'd0, bus.o_wra},       32'd0);
    check("rst.pcEn",      {31'd0, bus.o_pcEn},      32'd0);
    check("rst.idexFlush", {31'd0, bus.o_idexFlush}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("rst.hold.wra", {27'd0, bus.o_wra}, 32'd0);
    quiet();
    rstn     = 1'b1;
    sat_rstn = 1'b1;
    #1;
    check("rel.pcEn",   {31'd0, bus.o_pcEn},   32'd1);
    check("rel.ifidEn", {31'd0, bus.o_ifidEn}, 32'd1);
    @(posedge clk);
    #1;
    cycle("idle");

    // Load-use on an r8 writer: one bubble, then r8 enters EX.
    bus.i_wra = 5'd8; bus.i_wen = 1'b1; bus.i_loadUse = 1'b1;
    cycle("lu.stall");
    check("lu.bubble.wra", {27'd0, bus.o_wra}, 32'd0);
    bus.i_loadUse = 1'b0;
    cycle("lu.go");
    check("lu.issue.wra", {27'd0, bus.o_wra}, 32'd8);

    // Multi-cycle pause: one bubble per stalled cycle.
    bus.i_wra = 5'd3; bus.i_pause = 1'b1;
    for (int i = 0; i < 3; i++) cycle("pause");
    bus.i_pause = 1'b0;
    cycle("pause.rel");

    // Taken branch alone flushes IF/ID; with load-use it only stalls.
    bus.i_wra = 5'd5; bus.i_branchTaken = 1'b1;
    #1 check("br.flush", {31'd0, bus.o_ifidFlush}, 32'd1);
    cycle("br");
    bus.i_loadUse = 1'b1;
    #1 check("br.lu.noflush", {31'd0, bus.o_ifidFlush}, 32'd0);
    cycle("br.lu");
    quiet();
    cycle("br.done");

    // Multiply: exactly MUL_C busy cycles, then a one-cycle done.
    bus.i_mdStart = 1'b1; bus.i_wra = 5'd10; bus.i_wen = 1'b1;
    cycle("mul.issue");
    check("mul.issue.wra", {27'd0, bus.o_wra}, 32'd10);
    quiet();
    n = 0;
    while (bus.o_mdBusy && n < 100) begin
      check("mul.wait.pcEn", {31'd0, bus.o_pcEn}, 32'd0);
      if (n == 1) bus.i_branchTaken = 1'b1;
      if (n == 1) #1 check("mul.wait.br.noflush", {31'd0, bus.o_ifidFlush}, 32'd0);
      cycle("mul.wait");
      bus.i_branchTaken = 1'b0;
      n++;
    end
    check("mul.busy.cycles", n, MUL_C);
    check("mul.done", {31'd0, bus.o_mdDone}, 32'd1);
    cycle("mul.donecyc");
    check("mul.done.pulse", {31'd0, bus.o_mdDone}, 32'd0);
    check("mul.run.busy",   {31'd0, bus.o_mdBusy}, 32'd0);
    cycle("mul.run");

    // Divide: DIV_C busy cycles, then back-to-back multiply from MD_DONE.
    bus.i_mdStart = 1'b1; bus.i_mdIsDiv = 1'b1;
    cycle("div.issue");
    quiet();
    n = 0;
    while (bus.o_mdBusy && n < 100) begin
      cycle("div.wait");
      n++;
    end
    check("div.busy.cycles", n, DIV_C);
    check("div.done", {31'd0, bus.o_mdDone}, 32'd1);
    bus.i_mdStart = 1'b1;
    cycle("b2b.issue");
    quiet();
    check("b2b.busy", {31'd0, bus.o_mdBusy}, 32'd1);
    n = 0;
    while (bus.o_mdBusy && n < 100) begin
      cycle("b2b.wait");
      n++;
    end
    check("b2b.busy.cycles", n, MUL_C);
    cycle("b2b.donecyc");

    // Reset asserted mid-divide at cnt==10: RUN at once, no done pulse.
    bus.i_mdStart = 1'b1; bus.i_mdIsDiv = 1'b1;
    cycle("rdiv.issue");
    quiet();
    while (m_cnt != 10 && m_state == MD_WAIT) cycle("rdiv.wait");
    check("rdiv.busy.before", {31'd0, bus.o_mdBusy}, 32'd1);
    rstn = 1'b0;
    #1;
    check("rdiv.busy",   {31'd0, bus.o_mdBusy}, 32'd0);
    check("rdiv.done",   {31'd0, bus.o_mdDone}, 32'd0);
    check("rdiv.pcEn",   {31'd0, bus.o_pcEn},   32'd1);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    model_reset();
    for (int i = 0; i < 12; i++) cycle("rdiv.after");

    // Saturating counter preloaded at FFFFFFFE.
    check("sat.init", sat_cnt, 32'hFFFF_FFFE);
    sat_inc = 1'b1;
    @(posedge clk);
    #1;
    check("sat.top", sat_cnt, 32'hFFFF_FFFF);
    repeat (3) @(posedge clk);
    #1;
    check("sat.hold", sat_cnt, 32'hFFFF_FFFF);
    sat_inc = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stall_ctrl.md
# stall_ctrl

Pipeline stall/flush sequencer for the five-stage core: the control-side counterpart of the forwarding/pause unit. It takes hazard requests (pause, load-use, taken branch, multi-cycle multiply/divide start) and drives the PC and pipeline-register enables and flushes. It also emits the bubble-aware EX-stage destination-register stream that the forwarding unit tracks.

## Interface
Parameters:
- MUL_CYCLES, 4, EX-stall cycles for multiply (≥1)
- DIV_CYCLES, 32, EX-stall cycles for divide (≥MUL_CYCLES)

Ports:
- clk  in  1  core clock, rising edge
- rstn  in  1  asynchronous active-low reset
- i_wra  in  5  destination register of instruction in ID
- i_wen  in  1  ID instruction writes the register file
- i_pause  in  1  forwarding-unit pause request (combinational)
- i_loadUse  in  1  load-use hazard detected in ID
- i_branchTaken  in  1  branch/jump in ID resolved taken
- i_mdStart  in  1  ID instruction is mult/div
- i_mdIsDiv  in  1  qualifies i_mdStart: 1 = divide
- o_pcEn  out  1  PC register enable
- o_ifidEn  out  1  IF/ID register enable
- o_ifidFlush  out  1  IF/ID loads NOP
- o_idexFlush  out  1  ID/EX loads NOP (bubble)
- o_mdBusy  out  1  multi-cycle op in progress
- o_mdDone  out  1  one-cycle pulse, multi-cycle result valid
- o_wra  out  5  registered ID/EX destination; 0 on bubble
- o_perfStall  out  32  stall-cycle counter
- o_perfFlush  out  32  flush-cycle counter

## Operation
- FSM states: RUN, MD_WAIT, MD_DONE. Reset state RUN.
- stallReq = i_pause | i_loadUse. Evaluated only in RUN/MD_DONE.
- RUN / MD_DONE, stallReq=1: o_pcEn=0, o_ifidEn=0, o_idexFlush=1, o_ifidFlush=0. Branch and mdStart are ignored; the held ID instruction re-presents them next cycle.
- RUN / MD_DONE, stallReq=0: o_pcEn=1, o_ifidEn=1, o_idexFlush=0, o_ifidFlush=i_branchTaken.
- Issue also requires i_mdStart=1. On issue, next state is MD_WAIT and cnt loads (i_mdIsDiv ? DIV_CYCLES : MUL_CYCLES) − 1. The mult/div instruction itself enters ID/EX normally.
- MD_WAIT: o_pcEn=0, o_ifidEn=0, o_idexFlush=1, o_ifidFlush=0, o_mdBusy=1. All hazard/branch inputs are ignored. cnt decrements each cycle; at cnt==0 the next state is MD_DONE.
- MD_DONE: o_mdDone=1 for exactly one cycle. Controls otherwise behave as RUN, including accepting a back-to-back i_mdStart. Next state is RUN unless a new op issues.
- issue = (state≠MD_WAIT) & ~stallReq.
- o_wra updates on each edge: o_wra ← (issue & i_wen) ? i_wra : 5'd0.
- cnt width is $clog2(DIV_CYCLES+1).
- Outputs o_pcEn, o_ifidEn, o_ifidFlush, o_idexFlush, o_mdBusy, o_mdDone are combinational from state and inputs.
- Reset values: state=RUN, cnt=0, o_wra=0, perf counters=0. Combinational outputs therefore reflect RUN with the current inputs.

## Timing
- Load-use/pause: zero-latency stall, held as long as the request is held. One bubble per stalled cycle enters EX.
- Multiply: issue at edge T, then MD_WAIT for exactly MUL_CYCLES cycles, then o_mdDone in cycle T+MUL_CYCLES+1. Divide is the same with DIV_CYCLES.
- Taken branch: IF/ID flushed on the following edge, giving a single-cycle penalty.
- Reset asserted mid-MD_WAIT: state returns to RUN immediately. No o_mdDone is produced.
- With MUL_CYCLES=1, MD_WAIT lasts one cycle (cnt loads 0).

## Configuration
- STALL_CTRL_PERF_EN defined:
  - o_perfStall increments each cycle with o_pcEn=0.
  - o_perfFlush increments each cycle with o_ifidFlush=1.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are built.

## Structure
- Shared core package holds:
  - the FSM state enum (RUN=2'd0, MD_WAIT=2'd1, MD_DONE=2'd2)
  - the default MUL/DIV cycle constants
  - REG_ZERO=5'd0
- One sub-module: stall_perf_cnt, a 32-bit saturating counter with an increment input. It is instantiated twice, under the macro only.

## Test plan
- Reset with i_pause=1 and rstn low: o_wra=0, o_pcEn=0, o_idexFlush=1. Release with inputs quiet: o_pcEn=1, o_ifidEn=1.
- i_wra=5'd8, i_wen=1, i_loadUse high for 1 cycle: that cycle o_pcEn=0, o_idexFlush=1; next edge o_wra=0; following edge o_wra=8.
- i_mdStart=1, i_mdIsDiv=0 (MUL_CYCLES=4): exactly 4 cycles o_mdBusy=1/o_pcEn=0, then a 1-cycle o_mdDone, then RUN. The same with i_mdIsDiv=1 gives 32 busy cycles.
- i_branchTaken during MD_WAIT: no o_ifidFlush. i_branchTaken with i_loadUse in RUN: o_ifidFlush=0, stall only.
- Back-to-back mult asserted in MD_DONE: re-enters MD_WAIT with no RUN cycle between. Reset pulsed during divide cnt=10: RUN, no o_mdDone.
- STALL_CTRL_PERF_EN with a forced long stall: o_perfStall counts exact stall cycles; a preloaded value of 32'hFFFFFFFE saturates and holds at 32'hFFFFFFFF.
